control_unit: RTL and testbench

- Hardwired Moore control sequencer for the single-bus datapath.
- Replaces hand-timed bench stimulus: one control state per Clock cycle, with no # delays.
- Drives every datapath enable and select.
- Reads back IR and CON_FF from the datapath; runs fetch (T0–T2) and then an opcode-specific execute sequence (T3–T7).

---
 rtl/cpu_ctrl_pkg.sv | 62 ++++++
 rtl/control_decode.sv | 97 +++++++++
 rtl/control_unit.sv | 78 +++++++
 tb/tb_control_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds the instruction opcode map, the sequencer state encoding and the
// packed control word that the decoder hands back to control_unit.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_BRX  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    T7       = 4'd8,
    PAUSE    = 4'd9,
    HALT     = 4'd10
  } state_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic hiin, loin, yin, zin, pcin, irin, marin, mdrin, outportin, conin;
    logic hiout, loout, zhighout, zlowout, pcout, mdrout, inportout, cout;
    logic read, write, incpc, run, done;
  } ctrl_t;

  // nop and every opcode above halt finish at the end of fetch
  function automatic logic ends_in_fetch(input logic [OPC_W-1:0] op);
    return (op == OP_NOP) || (op > OP_HALT);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational control-word decoder.
// Ports: state_i  - current sequencer state
//        op_i     - opcode field IR[31:27]
//        con_ff_i - branch condition, only consulted in brx T6
//        ctrl_o   - every enable/select plus run and done
//        alu_op_o - ALU operation select (zero when the ALU is idle)
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t           state_i,
  input  logic [OPC_W-1:0] op_i,
  input  logic             con_ff_i,
  output ctrl_t            ctrl_o,
  output logic [OPC_W-1:0] alu_op_o
);

  // Control word as a function of (state, opcode); unlisted pairs stay idle
  always_comb begin
    ctrl_o   = '0;
    alu_op_o = {OPC_W{1'b0}};
    case (state_i)
      T0: begin ctrl_o.run = 1'b1; ctrl_o.pcout = 1'b1; ctrl_o.marin = 1'b1; ctrl_o.incpc = 1'b1; ctrl_o.zin = 1'b1; end
      T1: begin ctrl_o.run = 1'b1; ctrl_o.zlowout = 1'b1; ctrl_o.pcin = 1'b1; ctrl_o.read = 1'b1; ctrl_o.mdrin = 1'b1; end
      T2: begin
        ctrl_o.run = 1'b1; ctrl_o.mdrout = 1'b1; ctrl_o.irin = 1'b1;
        ctrl_o.done = ends_in_fetch(op_i);
      end
      T3: begin
        ctrl_o.run = 1'b1;
        case (op_i)
          OP_LD, OP_LDI, OP_ST: begin ctrl_o.grb = 1'b1; ctrl_o.baout = 1'b1; ctrl_o.yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.yin = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.yin = 1'b1; end
          OP_NEG, OP_NOT: begin ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = op_i; end
          OP_BRX:  begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.conin = 1'b1; end
          OP_JR:   begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.pcin = 1'b1; ctrl_o.done = 1'b1; end
          OP_IN:   begin ctrl_o.inportout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          OP_OUT:  begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.outportin = 1'b1; ctrl_o.done = 1'b1; end
          OP_MFHI: begin ctrl_o.hiout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          OP_MFLO: begin ctrl_o.loout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          // R15 <- PC; the assembler encodes 15 in the Rb field
          OP_JAL:  begin ctrl_o.pcout = 1'b1; ctrl_o.grb = 1'b1; ctrl_o.rin = 1'b1; end
          default: begin ctrl_o.run = 1'b1; end
        endcase
      end
      T4: begin
        ctrl_o.run = 1'b1;
        case (op_i)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = OP_ADD; end
          OP_ANDI: begin ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = OP_AND; end
          OP_ORI:  begin ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = OP_OR; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            ctrl_o.grc = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = op_i;
          end
          OP_MUL, OP_DIV: begin ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = op_i; end
          OP_NEG, OP_NOT: begin ctrl_o.zlowout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          OP_BRX:  begin ctrl_o.pcout = 1'b1; ctrl_o.yin = 1'b1; end
          OP_JAL:  begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.pcin = 1'b1; ctrl_o.done = 1'b1; end
          default: begin ctrl_o.run = 1'b1; end
        endcase
      end
      T5: begin
        ctrl_o.run = 1'b1;
        case (op_i)
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin ctrl_o.zlowout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          OP_LD, OP_ST:   begin ctrl_o.zlowout = 1'b1; ctrl_o.marin = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl_o.zlowout = 1'b1; ctrl_o.loin = 1'b1; end
          OP_BRX:  begin ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; alu_op_o = OP_ADD; end
          default: begin ctrl_o.run = 1'b1; end
        endcase
      end
      T6: begin
        ctrl_o.run = 1'b1;
        case (op_i)
          OP_LD:   begin ctrl_o.read = 1'b1; ctrl_o.mdrin = 1'b1; end
          // Read stays low so MDR loads from the bus, not memory
          OP_ST:   begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.mdrin = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl_o.zhighout = 1'b1; ctrl_o.hiin = 1'b1; ctrl_o.done = 1'b1; end
          OP_BRX:  begin ctrl_o.zlowout = 1'b1; ctrl_o.pcin = con_ff_i; ctrl_o.done = 1'b1; end
          default: begin ctrl_o.run = 1'b1; end
        endcase
      end
      T7: begin
        ctrl_o.run = 1'b1;
        case (op_i)
          OP_LD:   begin ctrl_o.mdrout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; ctrl_o.done = 1'b1; end
          OP_ST:   begin ctrl_o.write = 1'b1; ctrl_o.done = 1'b1; end
          default: begin ctrl_o.run = 1'b1; end
        endcase
      end
      default: begin ctrl_o = '0; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the single-bus datapath.
// Ports: Clock/clear (async active-low) - clock and reset
//        IR, CON_FF, Stop               - datapath feedback and pause request
//        opcode, register/bus/memory enables - decoded control word
//        Run, instr_done                - executing flag and end-of-instruction pulse
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              CON_FF,
  input  logic              Stop,
  output logic [OP_W-1:0]   opcode,
  output logic Gra, Grb, Grc, Rin, Rout, BAout,
  output logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
  output logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
  output logic Read, Write, IncPC,
  output logic Run,
  output logic instr_done
);

  state_t           state_q, state_d, entry_st_s;
  ctrl_t            cw_s;
  logic [OPC_W-1:0] op_s, alu_op_s;
  logic             unused_ir_s;

  assign op_s        = IR[DATA_W-1 -: OPC_W];
  assign unused_ir_s = ^IR[DATA_W-OPC_W-1:0];

  control_decode u_decode (
    .state_i  (state_q),
    .op_i     (op_s),
    .con_ff_i (CON_FF),
    .ctrl_o   (cw_s),
    .alu_op_o (alu_op_s)
  );

  // Next-state: Stop is only looked at when the sequencer is about to enter T0
  always_comb begin
    state_d = state_q;
    if (Stop) entry_st_s = PAUSE;
    else      entry_st_s = T0;
    case (state_q)
      RESET_ST: state_d = entry_st_s;
      PAUSE:    state_d = entry_st_s;
      HALT:     state_d = HALT;
      T0, T1, T2, T3, T4, T5, T6, T7: begin
        if (cw_s.done || (state_q == T7))               state_d = entry_st_s;
        else if ((state_q == T3) && (op_s == OP_HALT))  state_d = HALT;
        else                                            state_d = state_t'(state_q + 4'd1);
      end
      default: state_d = RESET_ST;
    endcase
  end

  // State register; clear aborts any instruction in flight
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= RESET_ST;
    else        state_q <= state_d;
  end

  assign opcode     = OP_W'(alu_op_s);
  assign Gra        = cw_s.gra;       assign Grb       = cw_s.grb;       assign Grc     = cw_s.grc;
  assign Rin        = cw_s.rin;       assign Rout      = cw_s.rout;      assign BAout   = cw_s.baout;
  assign HIin       = cw_s.hiin;      assign LOin      = cw_s.loin;      assign Yin     = cw_s.yin;
  assign Zin        = cw_s.zin;       assign PCin      = cw_s.pcin;      assign IRin    = cw_s.irin;
  assign MARin      = cw_s.marin;     assign MDRin     = cw_s.mdrin;     assign CONin   = cw_s.conin;
  assign Outportin  = cw_s.outportin; assign HIout     = cw_s.hiout;     assign LOout   = cw_s.loout;
  assign Zhighout   = cw_s.zhighout;  assign Zlowout   = cw_s.zlowout;   assign PCout   = cw_s.pcout;
  assign MDRout     = cw_s.mdrout;    assign Inportout = cw_s.inportout; assign Cout    = cw_s.cout;
  assign Read       = cw_s.read;      assign Write     = cw_s.write;     assign IncPC   = cw_s.incpc;
  assign Run        = cw_s.run;       assign instr_done = cw_s.done;

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit. The reference model keeps,
// per instruction, a queue of expected control words built from the
// instruction's step list, and tracks reset / pause / halt as simple modes.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        clear, Stop, CON_FF;
  logic [31:0] IR;
  logic [4:0]  opcode;
  logic Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin;
  logic Outportin, CONin, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout;
  logic Read, Write, IncPC, Run, instr_done;

  control_unit #(.DATA_W(32), .OP_W(5)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Outportin(Outportin), .CONin(CONin), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .Inportout(Inportout), .Cout(Cout), .Read(Read), .Write(Write), .IncPC(IncPC),
    .Run(Run), .instr_done(instr_done)
  );

  always #5 Clock = ~Clock;

  localparam logic [31:0] F_GRA = 32'd1 << 0,  F_GRB = 32'd1 << 1,  F_GRC = 32'd1 << 2;
  localparam logic [31:0] F_RIN = 32'd1 << 3,  F_ROUT = 32'd1 << 4, F_BAOUT = 32'd1 << 5;
  localparam logic [31:0] F_HIIN = 32'd1 << 6, F_LOIN = 32'd1 << 7, F_YIN = 32'd1 << 8;
  localparam logic [31:0] F_ZIN = 32'd1 << 9,  F_PCIN = 32'd1 << 10, F_IRIN = 32'd1 << 11;
  localparam logic [31:0] F_MARIN = 32'd1 << 12, F_MDRIN = 32'd1 << 13, F_OUTPIN = 32'd1 << 14;
  localparam logic [31:0] F_CONIN = 32'd1 << 15, F_HIOUT = 32'd1 << 16, F_LOOUT = 32'd1 << 17;
  localparam logic [31:0] F_ZHOUT = 32'd1 << 18, F_ZLOUT = 32'd1 << 19, F_PCOUT = 32'd1 << 20;
  localparam logic [31:0] F_MDROUT = 32'd1 << 21, F_INPOUT = 32'd1 << 22, F_COUT = 32'd1 << 23;
  localparam logic [31:0] F_READ = 32'd1 << 24, F_WRITE = 32'd1 << 25, F_INCPC = 32'd1 << 26;
  localparam logic [31:0] F_RUN = 32'd1 << 27,  F_DONE = 32'd1 << 28;
  localparam logic [31:0] BUS_M = F_ROUT | F_BAOUT | F_HIOUT | F_LOOUT | F_ZHOUT | F_ZLOUT |
                                  F_PCOUT | F_MDROUT | F_INPOUT | F_COUT;

  logic [31:0] obs_flags;
  assign obs_flags = {3'd0, instr_done, Run, IncPC, Write, Read, Cout, Inportout, MDRout,
                      PCout, Zlowout, Zhighout, LOout, HIout, CONin, Outportin, MDRin, MARin,
                      IRin, PCin, Zin, Yin, LOin, HIin, BAout, Rout, Rin, Grc, Grb, Gra};

  typedef struct packed { logic [31:0] f; logic [4:0] alu; } step_t;
  localparam int M_RESET = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

  step_t       exp_q[$];
  int          mode, step_idx, instr_cnt, halt_cyc, cyc_now;
  int          n_checks = 0, n_errors = 0;
  logic [4:0]  cur_op;
  logic        clear_armed;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d mode=%0d step=%0d op=%0d: got %h expected %h",
               tag, cyc_now, mode, step_idx, cur_op, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] f, input logic [4:0] a);
    step_t s;
    s.f = f; s.alu = a;
    exp_q.push_back(s);
  endtask

  // Expected control words for one instruction, fetch included
  task automatic build(input logic [4:0] op, input logic con);
    exp_q.delete();
    add(F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 5'd0);
    add(F_ZLOUT | F_PCIN | F_READ | F_MDRIN, 5'd0);
    add(F_MDROUT | F_IRIN, 5'd0);
    if (op == 5'd0) begin
      add(F_GRB | F_BAOUT | F_YIN, 5'd0); add(F_COUT | F_ZIN, 5'd3);
      add(F_ZLOUT | F_MARIN, 5'd0); add(F_READ | F_MDRIN, 5'd0); add(F_MDROUT | F_GRA | F_RIN, 5'd0);
    end else if (op == 5'd1) begin
      add(F_GRB | F_BAOUT | F_YIN, 5'd0); add(F_COUT | F_ZIN, 5'd3); add(F_ZLOUT | F_GRA | F_RIN, 5'd0);
    end else if (op == 5'd2) begin
      add(F_GRB | F_BAOUT | F_YIN, 5'd0); add(F_COUT | F_ZIN, 5'd3);
      add(F_ZLOUT | F_MARIN, 5'd0); add(F_GRA | F_ROUT | F_MDRIN, 5'd0); add(F_WRITE, 5'd0);
    end else if (op inside {[5'd3:5'd10]}) begin
      add(F_GRB | F_ROUT | F_YIN, 5'd0); add(F_GRC | F_ROUT | F_ZIN, op); add(F_ZLOUT | F_GRA | F_RIN, 5'd0);
    end else if (op inside {[5'd11:5'd13]}) begin
      add(F_GRB | F_ROUT | F_YIN, 5'd0);
      add(F_COUT | F_ZIN, (op == 5'd11) ? 5'd3 : ((op == 5'd12) ? 5'd5 : 5'd6));
      add(F_ZLOUT | F_GRA | F_RIN, 5'd0);
    end else if (op == 5'd14 || op == 5'd15) begin
      add(F_GRA | F_ROUT | F_YIN, 5'd0); add(F_GRB | F_ROUT | F_ZIN, op);
      add(F_ZLOUT | F_LOIN, 5'd0); add(F_ZHOUT | F_HIIN, 5'd0);
    end else if (op == 5'd16 || op == 5'd17) begin
      add(F_GRB | F_ROUT | F_ZIN, op); add(F_ZLOUT | F_GRA | F_RIN, 5'd0);
    end else if (op == 5'd18) begin
      add(F_GRA | F_ROUT | F_CONIN, 5'd0); add(F_PCOUT | F_YIN, 5'd0); add(F_COUT | F_ZIN, 5'd3);
      add(F_ZLOUT | (con ? F_PCIN : 32'd0), 5'd0);
    end else if (op == 5'd19) add(F_GRA | F_ROUT | F_PCIN, 5'd0);
    else if (op == 5'd20) begin
      add(F_PCOUT | F_GRB | F_RIN, 5'd0); add(F_GRA | F_ROUT | F_PCIN, 5'd0);
    end else if (op == 5'd21) add(F_INPOUT | F_GRA | F_RIN, 5'd0);
    else if (op == 5'd22) add(F_GRA | F_ROUT | F_OUTPIN, 5'd0);
    else if (op == 5'd23) add(F_HIOUT | F_GRA | F_RIN, 5'd0);
    else if (op == 5'd24) add(F_LOOUT | F_GRA | F_RIN, 5'd0);
    else if (op == 5'd26) add(32'd0, 5'd0);
    for (int i = 0; i < exp_q.size(); i++) exp_q[i].f = exp_q[i].f | F_RUN;
    if (op != 5'd26) exp_q[exp_q.size()-1].f = exp_q[exp_q.size()-1].f | F_DONE;
  endtask

  task automatic start_instr();
    logic [31:0] ir_v;
    logic        con_v;
    ir_v  = $urandom();
    con_v = ($urandom_range(0, 1) == 1);
    case (instr_cnt)
      0: ir_v = 32'h0100005F;
      1: ir_v = 32'h1A9A0000;
      2: begin ir_v = 32'h90800000; con_v = 1'b0; end
      3: begin ir_v = 32'h90800000; con_v = 1'b1; end
      4: ir_v = 32'h10800010;
      5: begin ir_v = 32'h01000020; clear_armed = 1'b1; end
      6: ir_v = 32'hD0000000;
      default: ;
    endcase
    instr_cnt++;
    IR = ir_v; CON_FF = con_v; cur_op = ir_v[31:27];
    build(cur_op, con_v);
    mode = M_RUN; step_idx = 0;
  endtask

  task automatic enter_t0();
    if (Stop) mode = M_PAUSE;
    else      start_instr();
  endtask

  // Advance the model across the clock edge that just happened
  task automatic model_step();
    case (mode)
      M_RESET: enter_t0();
      M_PAUSE: if (!Stop) start_instr();
      M_RUN: begin
        void'(exp_q.pop_front());
        step_idx++;
        if (exp_q.size() == 0) begin
          if (cur_op == 5'd26) begin mode = M_HALT; halt_cyc = 0; end
          else enter_t0();
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    logic [31:0] ef;
    logic [4:0]  ea;
    ef = (mode == M_RUN) ? exp_q[0].f : 32'd0;
    ea = (mode == M_RUN) ? exp_q[0].alu : 5'd0;
    check_eq("ctrl", obs_flags, ef);
    check_eq("alu_op", {27'd0, opcode}, {27'd0, ea});
    check_eq("bus_drivers", {31'd0, ($countones(obs_flags & BUS_M) > 1)}, 32'd0);
    check_eq("read_write", {31'd0, Read & Write}, 32'd0);
  endtask

  task automatic do_clear();
    #2 clear = 1'b0;
    #1 check_eq("clear_async", obs_flags, 32'd0);
    check_eq("clear_async_op", {27'd0, opcode}, 32'd0);
    @(posedge Clock); #1;
    check_eq("clear_held", obs_flags, 32'd0);
    clear = 1'b1;
    mode = M_RESET;
  endtask

  initial begin
    clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = 32'd0;
    mode = M_RESET; step_idx = 0; instr_cnt = 0; halt_cyc = 0; cyc_now = 0;
    cur_op = 5'd0; clear_armed = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("reset_ctrl", obs_flags, 32'd0);
    check_eq("reset_op", {27'd0, opcode}, 32'd0);
    clear = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      cyc_now = cyc;
      @(posedge Clock); #1;
      model_step();
      compare();
      if (mode == M_HALT || instr_cnt > 7)
        Stop = (mode == M_PAUSE) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      else
        Stop = 1'b0;
      if (mode == M_HALT) begin
        halt_cyc++;
        if (halt_cyc >= 20) do_clear();
      end else if (clear_armed && mode == M_RUN && cur_op == 5'd0 && step_idx == 5) begin
        clear_armed = 1'b0;
        do_clear();
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
